// File: rtl/note_scheduler_pkg.sv
// Shared types and constants for the note scheduler slice: key vector and
// index types, the scheduler state enum and a one-hot helper.
package note_scheduler_pkg;

  localparam int NUM_KEYS  = 8;
  localparam int KEY_IDX_W = 3;

  typedef logic [NUM_KEYS-1:0]  key_vec_t;
  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } sched_state_t;

  // Decode a key index into its one-hot key vector.
  function automatic key_vec_t idx_to_onehot(key_idx_t idx);
    return key_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Request/grant bundle between the debounced keys, the scheduler and the
// tone generator. The master side is the scheduler: it reads the request
// vector and drives the grant. The slave side is whoever raises requests
// and consumes the grant.
interface note_scheduler_if;
  import note_scheduler_pkg::*;

  key_vec_t req;
  logic     grant_valid;
  key_vec_t grant_onehot;
  key_idx_t grant_idx;
  logic     slot_done;

  modport master (
    input  req,
    output grant_valid,
    output grant_onehot,
    output grant_idx,
    output slot_done
  );

  modport slave (
    output req,
    input  grant_valid,
    input  grant_onehot,
    input  grant_idx,
    input  slot_done
  );

endinterface

// File: rtl/note_scheduler_rr_pick8.sv
// Combinational round-robin picker for 8 keys. The search starts one past
// last_idx and wraps, so last_idx itself is the lowest-priority candidate
// and a lone requester can still win.
module rr_pick8
  import note_scheduler_pkg::*;
(
  input  key_vec_t req,
  input  key_idx_t last_idx,
  output logic     any,
  output key_idx_t pick_idx,
  output key_vec_t pick_onehot
);

  logic [2*NUM_KEYS-1:0] doubled;
  key_vec_t              rotated;
  key_idx_t              start;
  key_idx_t              offset;

  // Rotate the request so the search start lands at bit 0, take the lowest
  // set bit, then add the start back to recover the absolute key index.
  always_comb begin
    start   = last_idx + 3'd1;
    doubled = {req, req};
    rotated = doubled[start +: NUM_KEYS];
    offset  = '0;
    for (int j = NUM_KEYS - 1; j >= 0; j--) begin
      if (rotated[j]) begin
        offset = key_idx_t'(j);
      end
    end
    any         = |req;
    pick_idx    = start + offset;
    pick_onehot = any ? idx_to_onehot(pick_idx) : '0;
  end

endmodule

// File: rtl/note_scheduler.sv
// Round-robin scheduler sharing one tone-synthesis channel among 8 keys.
// Each grant is frozen for a slot of HOLD_CYCLES cycles; at the end of a
// slot the next requester (if any) is granted with no bubble.
module note_scheduler
  import note_scheduler_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000,
  parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input logic             clk,
  input logic             rst,
  note_scheduler_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic             SINGLE_SLOT = (HOLD_CYCLES == 1);

  sched_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] next_cnt;
  key_idx_t         last_idx;
  key_idx_t         search_base;

  logic             grant_valid;
  key_vec_t         grant_onehot;
  key_idx_t         grant_idx;
  logic             slot_done;

  logic             pick_any;
  key_idx_t         pick_idx;
  key_vec_t         pick_onehot;

  // At a slot end the pointer is being updated to the current grant in the
  // same edge, so the search must already start from grant_idx.
  assign search_base = (state == ST_GRANT) ? grant_idx : last_idx;
  assign next_cnt    = cnt + CNT_W'(1);

  rr_pick8 u_pick (
    .req         (bus.req),
    .last_idx    (search_base),
    .any         (pick_any),
    .pick_idx    (pick_idx),
    .pick_onehot (pick_onehot)
  );

  // Scheduler FSM: slot counter, round-robin pointer and registered grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      grant_idx    <= '0;
      slot_done    <= 1'b0;
      cnt          <= '0;
      last_idx     <= key_idx_t'(NUM_KEYS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state        <= ST_GRANT;
            grant_valid  <= 1'b1;
            grant_idx    <= pick_idx;
            grant_onehot <= pick_onehot;
            cnt          <= '0;
            slot_done    <= SINGLE_SLOT;
          end else begin
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            slot_done    <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (cnt == LAST_CNT) begin
            last_idx <= grant_idx;
            if (pick_any) begin
              grant_idx    <= pick_idx;
              grant_onehot <= pick_onehot;
              cnt          <= '0;
              slot_done    <= SINGLE_SLOT;
            end else begin
              state        <= ST_IDLE;
              grant_valid  <= 1'b0;
              grant_idx    <= '0;
              grant_onehot <= '0;
              cnt          <= '0;
              slot_done    <= 1'b0;
            end
          end else begin
            cnt       <= next_cnt;
            slot_done <= (next_cnt == LAST_CNT);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.grant_valid  = grant_valid;
  assign bus.grant_onehot = grant_onehot;
  assign bus.grant_idx    = grant_idx;
  assign bus.slot_done    = slot_done;

endmodule

// File: tb/tb_note_scheduler.sv
// Testbench for note_scheduler: two instances (4-cycle slots and 1-cycle
// slots) share the same request and reset stimulus and are compared every
// cycle against a slot-level reference model of the round-robin rules.
module tb_note_scheduler;
  import note_scheduler_pkg::*;

  logic clk;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state per instance: whether a slot is running, the key
  // granted, how many cycles of the slot have elapsed (1..hold), and the
  // most recently completed grant.
  int hold    [2] = '{4, 1};
  bit m_valid [2];
  int m_idx   [2];
  int m_age   [2];
  int m_last  [2];

  note_scheduler_if bus_a ();
  note_scheduler_if bus_b ();

  note_scheduler #(.HOLD_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  note_scheduler #(.HOLD_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requesting key strictly after 'last', wrapping, with 'last' itself
  // considered only at the very end.
  function automatic int pickKey(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  // Advance one instance of the model by one clock edge.
  task automatic modelStep(input int n, input logic [7:0] r, input logic rs);
    if (rs) begin
      m_valid[n] = 1'b0;
      m_idx[n]   = 0;
      m_age[n]   = 0;
      m_last[n]  = 7;
    end else if (!m_valid[n]) begin
      if (r != 8'h00) begin
        m_idx[n]   = pickKey(r, m_last[n]);
        m_valid[n] = 1'b1;
        m_age[n]   = 1;
      end
    end else if (m_age[n] == hold[n]) begin
      m_last[n] = m_idx[n];
      if (r != 8'h00) begin
        m_idx[n] = pickKey(r, m_last[n]);
        m_age[n] = 1;
      end else begin
        m_valid[n] = 1'b0;
        m_idx[n]   = 0;
        m_age[n]   = 0;
      end
    end else begin
      m_age[n] = m_age[n] + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare all four outputs of one instance against its model.
  task automatic checkInst(input int n, input string name, input logic v,
                           input logic [7:0] oh, input logic [2:0] ix, input logic sd);
    logic [7:0] exp_oh;
    exp_oh = m_valid[n] ? (8'h01 << m_idx[n]) : 8'h00;
    checkOutput({name, ".grant_valid"},  {7'd0, v},  {7'd0, m_valid[n]});
    checkOutput({name, ".grant_onehot"}, oh,         exp_oh);
    checkOutput({name, ".grant_idx"},    {5'd0, ix}, m_valid[n] ? 8'(m_idx[n]) : 8'h00);
    checkOutput({name, ".slot_done"},    {7'd0, sd}, {7'd0, (m_valid[n] && m_age[n] == hold[n])});
  endtask

  // Drive one cycle of stimulus away from the edge, step the model at the
  // edge, then sample both instances shortly after.
  task automatic applyStimulus(input logic [7:0] r, input logic rs);
    @(negedge clk);
    bus_a.req = r;
    bus_b.req = r;
    rst       = rs;
    @(posedge clk);
    modelStep(0, r, rs);
    modelStep(1, r, rs);
    #1;
    checkInst(0, "h4", bus_a.grant_valid, bus_a.grant_onehot, bus_a.grant_idx, bus_a.slot_done);
    checkInst(1, "h1", bus_b.grant_valid, bus_b.grant_onehot, bus_b.grant_idx, bus_b.slot_done);
  endtask

  // Linear directed sequence followed by a randomized run.
  initial begin
    bit found;
    logic [7:0] r;
    bus_a.req = 8'h00;
    bus_b.req = 8'h00;
    rst       = 1'b1;
    for (int n = 0; n < 2; n++) modelStep(n, 8'h00, 1'b1);

    // Reset, then no requests.
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(8'h00, 1'b0);

    // Single one-cycle request for key 2.
    applyStimulus(8'h04, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b0);

    // All keys requesting: full rotation and beyond.
    for (int i = 0; i < 36; i++) applyStimulus(8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b0);

    // Keys 0 and 7: pointer wrap.
    for (int i = 0; i < 20; i++) applyStimulus(8'h81, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b0);

    // Lone requester repeats, then drops early in a slot.
    for (int i = 0; i < 13; i++) applyStimulus(8'h10, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(8'h10, 1'b0);
      found = (m_valid[0] && m_age[0] == 1);
    end
    for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b0);

    // Reset in the second cycle of the slot granting key 5.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus(8'hFF, 1'b0);
      found = (m_valid[0] && m_idx[0] == 5 && m_age[0] == 2);
    end
    vectors++;
    assert (found === 1'b1)
    else begin
      miscompares++;
      $error("[TB] FAIL reach_idx5: observed %0d expected %0d", found, 1);
    end
    applyStimulus(8'hFF, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(8'hFF, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(8'h00, 1'b0);

    // Randomized requests with occasional idle stretches and resets.
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      else if ($urandom_range(0, 2) == 0) r = 8'h01 << $urandom_range(0, 7);
      applyStimulus(r, ($urandom_range(0, 49) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Round-robin scheduler sharing the single tone-synthesis channel among 8 note-key requesters. Each cycle it samples an 8-bit request vector and grants exactly one key at a time. Each grant lasts a fixed minimum slot of HOLD_CYCLES cycles. It emits the grant both one-hot and as a 3-bit note index for the downstream tone generator. It sits between the debounced key inputs and the note/frequency lookup.

## Interface
- HOLD_CYCLES, default 1000: length of one grant slot in clock cycles. Must be ≥1.
- CNT_W, default $clog2(HOLD_CYCLES+1): width of the slot counter. Derived; never overridden.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset. One clock; reset is synchronous and active-high.
- req  input  8  per-key request. Level-sensitive; bit i = key i wants the channel.
- grant_valid  output  1  a slot is active.
- grant_onehot  output  8  one-hot granted key. All zero when grant_valid=0.
- grant_idx  output  3  binary index of the granted key. 0 when grant_valid=0.
- slot_done  output  1  single-cycle pulse on the last cycle of every slot.

## Operation
- State machine has two states:
  - IDLE: no grant.
  - GRANT: slot running; counter cnt goes 0..HOLD_CYCLES-1.
- Round-robin pointer last_idx (3 bits) holds the most recently granted index.
- Pick rule:
  - Search req starting at last_idx+1 (mod 8) upward, wrapping.
  - Take the first set bit.
  - last_idx itself is searched last, so a lone requester can be re-granted.
- IDLE behaviour:
  - If req≠0, load the pick into grant registers, set cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT behaviour:
  - Grant is frozen for the whole slot.
  - Changes on req during the slot are ignored, including the granted bit dropping.
  - While cnt<HOLD_CYCLES-1: increment cnt.
  - When cnt=HOLD_CYCLES-1: assert slot_done and set last_idx to grant_idx.
    - If req≠0, apply the pick rule to req in that same cycle. Load the new grant with cnt=0 and stay in GRANT, giving back-to-back slots.
    - If req=0, go to IDLE.
- grant_onehot is always consistent with grant_idx: onehot = 1<<idx while valid.
- Counter is unsigned, CNT_W bits. It never exceeds HOLD_CYCLES-1 and never wraps.
- HOLD_CYCLES=1: every GRANT cycle is a slot end, so there is re-arbitration every cycle and slot_done stays high while requests persist.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE
  - grant_valid=0, grant_onehot=0, grant_idx=0, slot_done=0
  - cnt=0
  - last_idx=7, so the first pick after reset prefers key 0.
- Latency:
  - req seen in IDLE at edge t gives grant outputs valid from edge t+1.
  - A slot occupies exactly HOLD_CYCLES consecutive cycles.
  - slot_done is high in the final one of them.
- Slot-end handover:
  - The new grant appears on the cycle immediately after the slot_done cycle.
  - There is no bubble if req≠0 at the slot_done cycle.
  - If req=0 at the slot_done cycle, there is exactly one cycle of grant_valid=0 before any new grant can appear.
- rst mid-slot wins over everything.
  - Next cycle all outputs and the pointer are at reset values.
  - Any active slot is abandoned without a slot_done pulse.

## Structure
- A shared package holds:
  - NUM_KEYS=8, KEY_IDX_W=3
  - the state enum (ST_IDLE, ST_GRANT)
  - typedef key_vec_t (8 bits) and key_idx_t (3 bits).
- One sub-module, rr_pick8, is combinational.
  - Inputs: req[7:0] and last_idx[2:0].
  - Outputs: any (1), pick_idx (3), pick_onehot (8).
  - It implements the rotate / priority-encode / un-rotate search.
- The top holds the FSM, counter, pointer and output registers.

## Test plan
- **Reset / no request:** with HOLD_CYCLES=4, rst for 2 cycles then req=0 for 10 cycles → grant_valid=0, grant_onehot=0x00, grant_idx=0, slot_done=0 throughout.
- **Single request:** req=0x04 for 1 cycle in IDLE, then 0 → grant_idx=2 and onehot=0x04 for exactly 4 cycles starting the next cycle. slot_done pulses on the 4th cycle. Then IDLE.
- **All requesting:** req=0xFF held → grant_idx sequence 0,1,2,…,7,0, 4 cycles each, no gap cycles. slot_done every 4th cycle.
- **Wrap-around:** req=0x81 held → grants alternate 0,7,0,7, confirming the pointer wraps 7→0.
- **Lone repeat and mid-slot drop:** req=0x10 held → consecutive slots all with idx 4. Then req drops to 0 at cycle 2 of a slot → grant holds through cycle 4, then IDLE.
- **Reset mid-slot:** with req=0xFF, rst at cycle 2 of the slot granting idx 5 → next cycle all outputs are 0 and there is no slot_done. After rst release the first grant is idx 0.
